// File: rtl/uart_tx_ring_fifo_if.sv
// Byte-source / UART-TX handshake bundle for the ring FIFO.
// The master is the byte source plus the UART engine; the slave is the FIFO.
interface uart_tx_ring_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output wr_data, wr_valid, tx_ready,
    input  wr_ready, tx_data, tx_valid
  );

  modport slave (
    input  wr_data, wr_valid, tx_ready,
    output wr_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_ring_fifo.sv
// Circular-buffer TX FIFO with first-word-fall-through output toward the UART engine.
// Supports any depth >= 2, a drop-newest or overwrite-oldest full policy, and a sticky overflow flag.
module uart_tx_ring_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH            = 16,
  parameter bit OVERWRITE_OLDEST = 1'b0,
  parameter int CNT_W            = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ena,
  input  logic                   flush,
  uart_tx_ring_fifo_if.slave     fifo_if,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  act;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  ovf_hit;
  logic                  drop_oldest;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty            = (count == '0);
  assign full             = (count == CNT_FULL);
  assign fifo_if.tx_valid = ena & ~empty;
  assign fifo_if.tx_data  = fifo_if.tx_valid ? mem[rd_ptr] : '0;
  // wr_ready is gated by reset so it drops the instant reset is applied
  assign fifo_if.wr_ready = reset_n & ena & (~full | OVERWRITE_OLDEST);

  assign act     = ena & ~flush;
  assign rd_fire = act & fifo_if.tx_valid & fifo_if.tx_ready;
  // A full FIFO in drop mode still takes the write when the head leaves in the same cycle
  assign wr_fire = act & fifo_if.wr_valid & (~full | OVERWRITE_OLDEST | rd_fire);
  assign ovf_hit = act & fifo_if.wr_valid & full & ~rd_fire;
  assign drop_oldest = wr_fire & full & ~rd_fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (ena && flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (act) begin
      if (wr_fire) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (rd_fire || drop_oldest) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (wr_fire && !rd_fire && !full) begin
        count <= count + CNT_W'(1);
      end else if (rd_fire && !wr_fire) begin
        count <= count - CNT_W'(1);
      end
      if (ovf_hit) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= fifo_if.wr_data;
    end
  end
endmodule

// File: doc/uart_tx_ring_fifo.md
Name: uart_tx_ring_fifo

Overview:
- Parametrised circular-buffer TX FIFO that sits between the command/byte source and the UART transmitter.
- Generalises the earlier shift-register TX FIFO with:
  - arbitrary width and depth;
  - read/write pointers with wrap-around;
  - occupancy count and full/empty flags;
  - a selectable full-policy mode (drop newest or overwrite oldest);
  - a sticky overflow flag and a synchronous flush.
- The output uses first-word-fall-through valid/ready toward the UART TX engine.

Parameters:
- DATA_WIDTH, 8, bits per character.
- DEPTH, 16, number of entries; any integer >= 2, not restricted to powers of two.
- OVERWRITE_OLDEST, 0, full policy: 0 = drop the incoming write; 1 = discard the oldest entry and accept the new one.
- CNT_W, $clog2(DEPTH+1), width of count.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ena  input  1  clock enable; when low, all state is frozen.
- flush  input  1  synchronous clear of contents and overflow.
- wr_data  input  DATA_WIDTH  character to enqueue.
- wr_valid  input  1  wr_data is valid this cycle.
- wr_ready  output  1  FIFO accepts the write this cycle.
- tx_data  output  DATA_WIDTH  head-of-queue character.
- tx_valid  output  1  tx_data holds a valid character.
- tx_ready  input  1  UART TX consumes the head this cycle.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set when a write hits a full FIFO.

Behaviour:
- Reset (reset_n low, asynchronous; takes effect immediately):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = 0.
  - Outputs: tx_valid = 0, empty = 1, full = 0, tx_data = 0, wr_ready = 0.
  - Storage is not reset.
  - Reset asserted mid-transfer discards all contents; the first cycle after release behaves as empty.
- Derived outputs (combinational from registered state):
  - empty = (count == 0); full = (count == DEPTH).
  - tx_valid = ena & ~empty.
  - tx_data = mem[rd_ptr] when tx_valid, else 0.
  - wr_ready = ena & (~full | OVERWRITE_OLDEST).
- Handshakes, evaluated only when ena = 1 and flush = 0:
  - A write fires when wr_valid & wr_ready.
  - A read fires when tx_valid & tx_ready.
- Write: mem[wr_ptr] <= wr_data; wr_ptr advances.
- Read: rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 advances to 0; no power-of-two masking is used.
- Count update:
  - +1 on a write only.
  - -1 on a read only.
  - Unchanged on a simultaneous write and read.
- Simultaneous write and read when empty: no read fires (tx_valid = 0). The write lands, and the character appears on tx_data the next cycle. Latency from write to tx_valid is 1 cycle.
- Simultaneous write and read when full: both fire and count stays at DEPTH. In mode 0 the write is accepted because wr_ready would otherwise be 0 and no overflow is flagged in that case; wr_ready itself stays 0 in mode 0 while full. The write is nevertheless accepted when tx_ready & tx_valid in the same cycle, with no overflow set.
- Full with wr_valid and no read:
  - Mode 0: the write is dropped, wr_ready = 0, overflow <= 1.
  - Mode 1: mem[wr_ptr] <= wr_data; both pointers advance; count stays at DEPTH; overflow <= 1. The oldest entry is lost and the head becomes the next-oldest entry.
- Flush (with ena = 1): has priority over reads and writes.
  - Pointers <= 0, count <= 0, overflow <= 0.
  - The same-cycle write is discarded.
- ena = 0:
  - No pointer, count or overflow change.
  - wr_ready = 0 and tx_valid = 0, so no transfers occur.
  - Flush is ignored.
- The overflow flag stays set until flush or reset; further overflows keep it at 1.
- Ordering is strictly FIFO: the output sequence equals the accepted-write sequence minus any entries overwritten in mode 1.

Test Plan:
1. DEPTH=16. Reset, then write 0x41..0x45 with tx_ready=0 → count=5, tx_data=0x41, empty=0. Then hold tx_ready=1 → 0x41..0x45 emitted on consecutive cycles, then empty=1 and tx_data=0.
2. Wrap-around, DEPTH=5. Write 3, read 3, write 5 (0x10..0x14), read all → order 0x10..0x14, full=1 after the fifth write, wr_ptr wraps 4→0.
3. Mode 0, DEPTH=4. Fill with 0xA0..0xA3, then write 0xFF with tx_ready=0 → wr_ready=0, overflow=1, and the readout is 0xA0..0xA3 only.
4. Mode 1, DEPTH=4. Fill with 0xA0..0xA3, then write 0xB0 → count=4, overflow=1, readout 0xA1, 0xA2, 0xA3, 0xB0.
5. Simultaneous events:
   - Write while full with tx_ready=1 → count stays 4, no overflow.
   - Write while empty with tx_ready=1 → tx_valid rises the next cycle.
   - flush with wr_valid=1 → count=0, overflow=0, the write is discarded.
6. ena and reset:
   - ena=0 for 3 cycles with wr_valid and tx_ready high → count and pointers unchanged.
   - Assert reset_n low between clock edges mid-stream → outputs reach reset values immediately, and the FIFO is empty after release.
